ser_2_par_collector: RTL

Serial-to-parallel collector that sits directly downstream of the parallel-to-serial shift register. It reassembles DATA_WIDTH-bit words from an LSB-first serial bit stream framed by a start strobe. Completed words are buffered in a 2-entry output queue and presented on a valid/ready handshake. Framing errors and buffer overflow are flagged with single-cycle pulses.

---
 rtl/ser_2_par_collector_if.sv | 39 +++
 rtl/ser_2_par_collector.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ser_2_par_collector_if.sv
// ----------------------------------------------------------------------------
// ser_2_par_collector_if
//   Bundles the serial input side and the word output side of the
//   serial-to-parallel collector.
//
//   Signals:
//     sin         serial data bit, LSB first
//     sin_start   marks the cycle that carries bit 0 of a new word
//     dout        head-of-queue word (0 when dout_valid is low)
//     dout_valid  head of queue holds a word
//     dout_ready  consumer accepts the head word
//     frame_err   one-cycle pulse: partial word discarded by a new start
//     overflow    one-cycle pulse: completed word dropped, queue full
//
//   Modports:
//     master  the environment: drives the serial stream and dout_ready
//     slave   the collector: drives the word, valid and the flags
// ----------------------------------------------------------------------------
interface ser_2_par_collector_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  sin;
    logic                  sin_start;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic                  frame_err;
    logic                  overflow;

    modport master (
        output sin, sin_start, dout_ready,
        input  dout, dout_valid, frame_err, overflow
    );

    modport slave (
        input  sin, sin_start, dout_ready,
        output dout, dout_valid, frame_err, overflow
    );
endinterface

// File: rtl/ser_2_par_collector.sv
// ----------------------------------------------------------------------------
// ser_2_par_collector
//   Reassembles DATA_WIDTH-bit words from an LSB-first serial stream framed by
//   sin_start, buffers completed words in a 2-entry FIFO and presents them on
//   a valid/ready handshake.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    ser_2_par_collector_if.slave (sin, sin_start, dout_ready in;
//            dout, dout_valid, frame_err, overflow out)
//
//   dout/dout_valid/frame_err/overflow are all flops; dout_ready only reaches
//   them through the queue next-state logic.
// ----------------------------------------------------------------------------
module ser_2_par_collector #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    ser_2_par_collector_if.slave    bus
);

    localparam int                CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // collector state
    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic                   frame_err_q;
    logic                   overflow_q;

    // output queue: entry 0 is always the head
    logic [1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [1:0]                 occ_q, occ_d;
    logic [DATA_WIDTH-1:0]      dout_q;
    logic                       dout_valid_q;

    logic                       pop;
    logic                       word_done;
    logic                       push_ok;
    logic                       drop;
    logic [DATA_WIDTH-1:0]      done_word;

    // ------------------------------------------------------------------
    // Word completion: the last bit is merged combinationally so the full
    // word can be pushed on the same edge that samples it.
    // ------------------------------------------------------------------
    always_comb begin
        pop       = (occ_q != 2'd0) && bus.dout_ready;
        word_done = (state_q == COLLECT) && !bus.sin_start && (cnt_q == LAST);
        done_word = shift_q | (DATA_WIDTH'(bus.sin) << cnt_q);
        // A full queue still takes the word if the head leaves this cycle.
        push_ok   = word_done && ((occ_q != 2'd2) || pop);
        drop      = word_done && (occ_q == 2'd2) && !pop;
    end

    // ------------------------------------------------------------------
    // Queue next state
    // ------------------------------------------------------------------
    always_comb begin
        mem_d = mem_q;
        occ_d = occ_q;
        case ({push_ok, pop})
            2'b10: begin
                // occupancy 0 -> slot 0, occupancy 1 -> slot 1
                mem_d[occ_q[0]] = done_word;
                occ_d           = occ_q + 2'd1;
            end
            2'b01: begin
                mem_d[0] = mem_q[1];
                occ_d    = occ_q - 2'd1;
            end
            2'b11: begin
                // occupancy unchanged; the new word goes behind whatever
                // remains after the head leaves
                if (occ_q == 2'd1) begin
                    mem_d[0] = done_word;
                end else begin
                    mem_d[0] = mem_q[1];
                    mem_d[1] = done_word;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q        <= '0;
            occ_q        <= 2'd0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            occ_q        <= occ_d;
            // outputs registered from the next queue state so they line up
            // with occ_q/mem_q and read 0 when empty
            dout_q       <= (occ_d != 2'd0) ? mem_d[0] : '0;
            dout_valid_q <= (occ_d != 2'd0);
        end
    end

    // ------------------------------------------------------------------
    // Collector FSM with registered flag outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overflow_q  <= drop;
            case (state_q)
                IDLE: begin
                    if (bus.sin_start) begin
                        shift_q <= DATA_WIDTH'(bus.sin);
                        cnt_q   <= CNT_W'(1);
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (bus.sin_start) begin
                        // restart wins even on the last-bit cycle
                        shift_q     <= DATA_WIDTH'(bus.sin);
                        cnt_q       <= CNT_W'(1);
                        frame_err_q <= 1'b1;
                    end else if (cnt_q == LAST) begin
                        shift_q <= '0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        shift_q[cnt_q] <= bus.sin;
                        cnt_q          <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overflow   = overflow_q;

endmodule
